// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store access stage with internal data RAM and timed IO bridge
module mem_access_unit #(
    parameter int          DM_WORDS   = 4096,
    parameter logic [31:0] DM_LIMIT   = 32'h0000_3000,
    parameter int          IO_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_bus_err,
    output logic        io_req,
    output logic        io_we,
    output logic [29:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_be,
    input  logic        io_ack,
    input  logic [31:0] io_rdata
);

    localparam int AW = $clog2(DM_WORDS);
    localparam int CW = $clog2(IO_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(IO_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DM_RESP,
        S_IO_WAIT,
        S_IO_RESP,
        S_ERR_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          signed_q, signed_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          bus_err_q, bus_err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   io_rd_q, io_rd_d;

    logic          accept;
    logic          req_misalign;
    logic          req_is_dm;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata_sh;
    logic          dm_access;
    logic [AW-1:0] ram_idx;
    logic [CW-1:0] cnt_inc;

    logic [31:0]   dm_mem [DM_WORDS];
    logic [31:0]   dm_rdata_q;

    logic [31:0]   raw_word;
    logic [31:0]   raw_shifted;
    logic [31:0]   load_ext;

    // Request decode: lane enables, alignment and address map
    always_comb begin
        req_misalign = 1'b0;
        req_be       = 4'b1111;
        case (req_size)
            2'b00: req_be = 4'b0001 << req_addr[1:0];
            2'b01: begin
                req_be       = 4'b0011 << req_addr[1:0];
                req_misalign = req_addr[0];
            end
            default: begin
                req_be       = 4'b1111;
                req_misalign = |req_addr[1:0];
            end
        endcase
    end

    assign req_is_dm    = ({16'h0000, req_addr[15:0]} < DM_LIMIT);
    assign req_wdata_sh = req_wdata << {req_addr[1:0], 3'b000};
    assign accept       = (state_q == S_IDLE) && req_valid;
    assign dm_access    = accept && !req_misalign && req_is_dm;
    assign ram_idx      = req_addr[AW+1:2];
    assign cnt_inc      = cnt_q + CW'(1);

    // Data RAM is not reset; stores and registered reads both happen on the accept edge
    always_ff @(posedge clk) begin
        if (dm_access && req_we) begin
            for (int b = 0; b < 4; b++) begin
                if (req_be[b]) begin
                    dm_mem[ram_idx][8*b +: 8] <= req_wdata_sh[8*b +: 8];
                end
            end
        end
        if (dm_access && !req_we) begin
            dm_rdata_q <= dm_mem[ram_idx];
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        size_d    = size_q;
        signed_d  = signed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        bus_err_d = bus_err_q;
        cnt_d     = cnt_q;
        io_rd_d   = io_rd_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    we_d      = req_we;
                    size_d    = req_size;
                    signed_d  = req_signed;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata_sh;
                    be_d      = req_be;
                    bus_err_d = 1'b0;
                    if (req_misalign) begin
                        state_d = S_ERR_RESP;
                    end else if (req_is_dm) begin
                        state_d = S_DM_RESP;
                    end else begin
                        state_d = S_IO_WAIT;
                    end
                end
            end
            S_IO_WAIT: begin
                // An ack in the final counted cycle still completes the access
                if (io_ack) begin
                    io_rd_d = io_rdata;
                    state_d = S_IO_RESP;
                end else if (cnt_inc == TO_MAX) begin
                    bus_err_d = 1'b1;
                    state_d   = S_ERR_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DM_RESP,
            S_IO_RESP,
            S_ERR_RESP: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            signed_q  <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
            io_rd_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
            io_rd_q   <= io_rd_d;
        end
    end

    // Load alignment and extension from the latched request
    always_comb begin
        raw_word    = (state_q == S_IO_RESP) ? io_rd_q : dm_rdata_q;
        raw_shifted = raw_word >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & raw_shifted[7]}}, raw_shifted[7:0]};
            2'b01:   load_ext = {{16{signed_q & raw_shifted[15]}}, raw_shifted[15:0]};
            default: load_ext = raw_shifted;
        endcase
    end

    assign req_ready     = (state_q == S_IDLE);
    assign resp_valid    = (state_q == S_DM_RESP) || (state_q == S_IO_RESP) || (state_q == S_ERR_RESP);
    assign resp_rdata    = (((state_q == S_DM_RESP) || (state_q == S_IO_RESP)) && !we_q) ? load_ext : 32'h0;
    assign resp_misalign = (state_q == S_ERR_RESP) && !bus_err_q;
    assign resp_bus_err  = (state_q == S_ERR_RESP) && bus_err_q;
    assign io_req        = (state_q == S_IO_WAIT);
    assign io_we         = io_req && we_q;
    assign io_addr       = addr_q[31:2];
    assign io_wdata      = wdata_q;
    assign io_be         = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed table, reset and randomized checks for mem_access_unit
module tb_mem_access_unit;

    localparam int TO  = 4;
    localparam int DMW = 256;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;
    logic        resp_bus_err;
    logic        io_req;
    logic        io_we;
    logic [29:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_be;
    logic        io_ack;
    logic [31:0] io_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          lat;
        int          io_cyc;
        logic        io_we;
        logic [29:0] io_addr;
        logic [31:0] io_wdata;
        logic [3:0]  io_be;
        logic        stable;
    } obs_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack;
        logic [31:0] io_word;
        obs_t        exp;
    } vec_t;

    int          n_chk;
    int          n_fail;
    vec_t        tbl [20];
    logic [7:0]  bmem [DMW*4];

    mem_access_unit #(
        .DM_WORDS   (DMW),
        .DM_LIMIT   (32'h0000_3000),
        .IO_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .resp_bus_err  (resp_bus_err),
        .io_req        (io_req),
        .io_we         (io_we),
        .io_addr       (io_addr),
        .io_wdata      (io_wdata),
        .io_be         (io_be),
        .io_ack        (io_ack),
        .io_rdata      (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] wd, input int ack,
                                input logic [31:0] iow, input logic [31:0] rd, input logic mis,
                                input logic err, input int lat, input int ioc,
                                input logic [29:0] ia, input logic [31:0] iwd, input logic [3:0] be);
        vec_t v;
        v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd; v.ack = ack; v.io_word = iow;
        v.exp.rdata = rd; v.exp.mis = mis; v.exp.err = err; v.exp.lat = lat; v.exp.io_cyc = ioc;
        v.exp.io_we = we; v.exp.io_addr = ia; v.exp.io_wdata = iwd; v.exp.io_be = be;
        v.exp.stable = 1'b1;
        return v;
    endfunction

    // Reference model: byte-addressed memory and lane arithmetic
    function automatic obs_t model(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input int ack, input logic [31:0] io_word);
        obs_t o;
        int n, off, b;
        logic [31:0] v;
        o = '{default: 0};
        o.stable = 1'b1;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr % 4);
        if ((n == 2 && off % 2 != 0) || (n == 4 && off != 0)) begin
            o.mis = 1'b1;
            o.lat = 1;
            return o;
        end
        v = 32'h0;
        if (addr[15:0] < 16'h3000) begin
            b = int'(addr % (DMW * 4));
            o.lat = 1;
            for (int k = 0; k < n; k++) begin
                if (we) bmem[b+k] = wdata[8*k +: 8];
                else    v[8*k +: 8] = bmem[b+k];
            end
        end else begin
            o.io_we    = we;
            o.io_addr  = addr[31:2];
            o.io_wdata = wdata << (8 * off);
            for (int k = 0; k < n; k++) o.io_be[off+k] = 1'b1;
            if (ack >= 1 && ack <= TO) begin
                o.lat    = ack + 1;
                o.io_cyc = ack;
                for (int k = 0; k < n; k++) v[8*k +: 8] = io_word[8*(off+k) +: 8];
            end else begin
                o.err    = 1'b1;
                o.lat    = TO + 1;
                o.io_cyc = TO;
                return o;
            end
        end
        if (sgn && n < 4 && v[8*n-1]) begin
            for (int j = 8 * n; j < 32; j++) v[j] = 1'b1;
        end
        o.rdata = we ? 32'h0 : v;
        return o;
    endfunction

    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int ack,
                           input logic [31:0] io_word, output obs_t o);
        int  ioc;
        bit  done;
        o = '{default: 0};
        o.stable = 1'b1;
        ioc  = 0;
        done = 0;
        @(negedge clk);
        chk("idle.req_ready", req_ready, 1);
        chk("idle.resp_valid", resp_valid, 0);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (io_req) begin
                ioc++;
                if (ioc == 1) begin
                    o.io_we = io_we; o.io_addr = io_addr; o.io_wdata = io_wdata; o.io_be = io_be;
                end else if (io_we !== o.io_we || io_addr !== o.io_addr ||
                             io_wdata !== o.io_wdata || io_be !== o.io_be) begin
                    o.stable = 1'b0;
                end
                if (ioc == ack) begin
                    io_ack = 1'b1; io_rdata = io_word;
                end else begin
                    io_ack = 1'b0; io_rdata = $urandom;
                end
            end else begin
                io_ack = 1'b0;
            end
            if (resp_valid) begin
                o.rdata = resp_rdata; o.mis = resp_misalign; o.err = resp_bus_err;
                o.lat = c; done = 1;
            end
        end
        io_ack   = 1'b0;
        o.io_cyc = ioc;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL resp_wait: no resp_valid within 40 cycles of accept at addr %h", addr);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t g, input obs_t e);
        chk({tag, ".rdata"},   g.rdata, e.rdata);
        chk({tag, ".misalign"}, g.mis, e.mis);
        chk({tag, ".bus_err"}, g.err, e.err);
        chk({tag, ".latency"}, g.lat, e.lat);
        chk({tag, ".io_cycles"}, g.io_cyc, e.io_cyc);
        if (e.io_cyc > 0) begin
            chk({tag, ".io_we"},   g.io_we, e.io_we);
            chk({tag, ".io_addr"}, g.io_addr, e.io_addr);
            chk({tag, ".io_be"},   g.io_be, e.io_be);
            chk({tag, ".io_stable"}, g.stable, 1);
            if (e.io_we) chk({tag, ".io_wdata"}, g.io_wdata, e.io_wdata);
        end
    endtask

    initial begin
        obs_t got, exp;
        logic        r_we, r_sgn;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata, r_word;
        int          r_ack;

        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; io_ack = 1'b0; io_rdata = 32'h0;

        #7;
        chk("rst.req_ready", req_ready, 1);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.resp_misalign", resp_misalign, 0);
        chk("rst.resp_bus_err", resp_bus_err, 0);
        chk("rst.resp_rdata", resp_rdata, 0);
        chk("rst.io_req", io_req, 0);
        chk("rst.io_we", io_we, 0);
        chk("rst.io_addr", io_addr, 0);
        chk("rst.io_wdata", io_wdata, 0);
        chk("rst.io_be", io_be, 0);
        @(negedge clk);
        rst_n = 1'b1;

        //           we    sz     sg    addr          wdata         ack iow           rdata         mis  err  lat ioc io_addr   io_wdata      be
        tbl[0]  = mk(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[1]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[2]  = mk(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_0080, 0, 32'h0,       32'h0,        1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[3]  = mk(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,        0, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[4]  = mk(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,        0, 32'h0,        32'h00000080, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[5]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0012, 32'h0000_1234, 0, 32'h0,       32'h0,        1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[6]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        0, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[7]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,        0, 32'h0,        32'h0,        1'b1, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[8]  = mk(1'b1, 2'd1, 1'b0, 32'h0000_0011, 32'h0000_FFFF, 0, 32'h0,       32'h0,        1'b1, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[9]  = mk(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,        0, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[10] = mk(1'b1, 2'd2, 1'b0, 32'h0000_7F10, 32'hA5A5A5A5, 3, 32'h0,        32'h0,        1'b0, 1'b0, 4, 3, 30'h1FC4, 32'hA5A5A5A5, 4'hF);
        tbl[11] = mk(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0,        0, 32'h0,        32'h0,        1'b0, 1'b1, 5, 4, 30'h1000, 32'h0,        4'hF);
        tbl[12] = mk(1'b0, 2'd1, 1'b1, 32'h0000_5006, 32'h0,        1, 32'h8001_0000, 32'hFFFF8001, 1'b0, 1'b0, 2, 1, 30'h1401, 32'h0,       4'hC);
        tbl[13] = mk(1'b0, 2'd0, 1'b0, 32'h0000_6001, 32'h0,        4, 32'h0000_AB00, 32'h000000AB, 1'b0, 1'b0, 5, 4, 30'h1800, 32'h0,       4'h2);
        tbl[14] = mk(1'b1, 2'd0, 1'b0, 32'h0000_9003, 32'h0000_005A, 2, 32'h0,       32'h0,        1'b0, 1'b0, 3, 2, 30'h2400, 32'h5A000000, 4'h8);
        tbl[15] = mk(1'b0, 2'd3, 1'b0, 32'h0001_0010, 32'h0,        0, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[16] = mk(1'b1, 2'd2, 1'b0, 32'h0000_2FFC, 32'h11223344, 0, 32'h0,        32'h0,        1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[17] = mk(1'b0, 2'd1, 1'b0, 32'h0000_2FFE, 32'h0,        0, 32'h0,        32'h00001122, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);
        tbl[18] = mk(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0,        1, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, 2, 1, 30'h0C00, 32'h0,        4'hF);
        tbl[19] = mk(1'b0, 2'd0, 1'b1, 32'h0000_2FFD, 32'h0,        0, 32'h0,        32'h00000033, 1'b0, 1'b0, 1, 0, 30'h0,    32'h0,        4'h0);

        for (int i = 0; i < 20; i++) begin
            run_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                    tbl[i].ack, tbl[i].io_word, got);
            check_obs($sformatf("vec%0d", i), got, tbl[i].exp);
        end

        // Reset while an IO access is outstanding
        @(negedge clk);
        chk("rstio.req_ready", req_ready, 1);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_8000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstio.io_req_up", io_req, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstio.io_req_async", io_req, 0);
        chk("rstio.req_ready_async", req_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstio.resp_valid_in_rst", resp_valid, 0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstio.resp_valid_after", resp_valid, 0);
            chk("rstio.io_req_after", io_req, 0);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, got);
        exp = '{default: 0};
        exp.rdata = 32'h1234BEEF; exp.lat = 1; exp.stable = 1'b1;
        check_obs("rstio.dm_load", got, exp);

        // Randomized phase: fill the RAM through the DUT, then mixed traffic
        for (int i = 0; i < DMW; i++) begin
            r_wdata = $urandom;
            r_addr  = i * 4;
            exp = model(1'b1, 2'd2, 1'b0, r_addr, r_wdata, 0, 32'h0);
            run_req(1'b1, 2'd2, 1'b0, r_addr, r_wdata, 0, 32'h0, got);
            check_obs($sformatf("init%0d", i), got, exp);
        end
        for (int i = 0; i < 300; i++) begin
            r_we    = 1'($urandom);
            r_size  = 2'($urandom);
            r_sgn   = 1'($urandom);
            r_wdata = $urandom;
            r_word  = $urandom;
            r_ack   = $urandom_range(0, 6);
            r_addr  = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr[15:0] = 16'($urandom_range(0, 32'h2FFF));
            else                           r_addr[15:0] = 16'($urandom_range(32'h3000, 32'hFFFF));
            if ($urandom_range(0, 4) != 0) begin
                if (r_size == 2'd1)      r_addr[0]   = 1'b0;
                else if (r_size[1])      r_addr[1:0] = 2'b00;
            end
            exp = model(r_we, r_size, r_sgn, r_addr, r_wdata, r_ack, r_word);
            run_req(r_we, r_size, r_sgn, r_addr, r_wdata, r_ack, r_word, got);
            check_obs($sformatf("rnd%0d", i), got, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
